// File: rtl/spi_tx_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | spi_tx_arbiter_pkg                                                         |
// | State encodings and width helper shared by the SPI TX arbiter slice.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package spi_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int width_of(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_rr_picker.sv
// +----------------------------------------------------------------------------+
// | spi_rr_picker                                                              |
// | Combinational round-robin select: first request above the pointer, wraps.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_rr_picker
  import spi_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = width_of(NUM_REQ - 1)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_any
);

  int w_pos;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_pos    = 0;
    // Offset k=NUM_REQ revisits the pointer itself, so it has lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_pos = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[PTR_W'(w_pos)]) begin
        o_any                     = 1'b1;
        o_idx                     = PTR_W'(w_pos);
        o_onehot[PTR_W'(w_pos)]   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_tx_arbiter.sv
// +----------------------------------------------------------------------------+
// | spi_tx_arbiter                                                             |
// | Round-robin sequencer sharing one SPI master TX engine between NUM_REQ     |
// | requesters. Optional watchdog on the TX done wait: SPI_ARB_TIMEOUT_EN.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_tx_arbiter
  import spi_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int GAP_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      In_clk,
  input  logic                      In_rst_n,
  input  logic [NUM_REQ-1:0]        In_req,
  input  logic [NUM_REQ*DATA_W-1:0] In_data,
  output logic [NUM_REQ-1:0]        Out_grant,
  output logic [NUM_REQ-1:0]        Out_done,
  output logic                      Out_timeout,
  output logic                      Out_tx_start,
  output logic [DATA_W-1:0]         Out_tx_data,
  input  logic                      In_tx_busy,
  input  logic                      In_tx_done,
  output logic                      Out_busy
);

  localparam int c_PTR_W    = width_of(NUM_REQ - 1);
  localparam int c_CNT_W    = width_of((GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES);
  localparam int c_GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam arb_state_t c_AFTER_FRAME = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  arb_state_t           r_state, w_state_nxt;
  logic [c_PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [c_PTR_W-1:0]   r_owner, w_owner_nxt;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0]   r_done, w_done_nxt;
  logic                 r_tx_start, w_tx_start_nxt;
  logic [DATA_W-1:0]    r_tx_data, w_tx_data_nxt;
  logic                 r_busy;

  logic [NUM_REQ-1:0]   w_pick_onehot;
  logic [c_PTR_W-1:0]   w_pick_idx;
  logic                 w_pick_any;
  logic [NUM_REQ-1:0]   w_owner_onehot;
  logic                 w_unused_tx_busy;

  // TX busy is informational; sequencing relies solely on the done pulse.
  assign w_unused_tx_busy = In_tx_busy;
  assign w_owner_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int c_TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  logic r_timeout, w_timeout_nxt;
  assign Out_timeout = r_timeout;
`else
  assign Out_timeout = 1'b0;
`endif

  spi_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (c_PTR_W)
  ) u_picker (
    .i_req    (In_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_owner_nxt    = r_owner;
    w_cnt_nxt      = r_cnt;
    w_grant_nxt    = '0;
    w_done_nxt     = '0;
    w_tx_start_nxt = 1'b0;
    w_tx_data_nxt  = r_tx_data;
`ifdef SPI_ARB_TIMEOUT_EN
    w_timeout_nxt  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_grant_nxt   = w_pick_onehot;
          w_ptr_nxt     = w_pick_idx;
          w_owner_nxt   = w_pick_idx;
          w_tx_data_nxt = In_data[w_pick_idx*DATA_W +: DATA_W];
          w_state_nxt   = ST_START;
        end
      end
      ST_START: begin
        w_tx_start_nxt = 1'b1;
        w_cnt_nxt      = '0;
        w_state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        if (In_tx_done) begin
          w_done_nxt  = w_owner_onehot;
          w_cnt_nxt   = '0;
          w_state_nxt = c_AFTER_FRAME;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (r_cnt == c_CNT_W'(c_TO_LAST)) begin
          w_timeout_nxt = 1'b1;
          w_done_nxt    = w_owner_onehot;
          w_cnt_nxt     = '0;
          w_state_nxt   = c_AFTER_FRAME;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end
      ST_GAP: begin
        if (r_cnt == c_CNT_W'(c_GAP_LAST)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge In_clk) begin
    if (!In_rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= c_PTR_W'(NUM_REQ - 1);
      r_owner    <= '0;
      r_cnt      <= '0;
      r_grant    <= '0;
      r_done     <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_busy     <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_cnt      <= w_cnt_nxt;
      r_grant    <= w_grant_nxt;
      r_done     <= w_done_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
`ifdef SPI_ARB_TIMEOUT_EN
      r_timeout  <= w_timeout_nxt;
`endif
    end
  end

  assign Out_grant    = r_grant;
  assign Out_done     = r_done;
  assign Out_tx_start = r_tx_start;
  assign Out_tx_data  = r_tx_data;
  assign Out_busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_spi_tx_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_spi_tx_arbiter                                                          |
// | Self-checking bench for spi_tx_arbiter with a TX engine model.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_spi_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  In_req;
  logic [31:0] In_data;
  logic [3:0]  Out_grant, Out_done;
  logic        Out_timeout, Out_tx_start, Out_busy;
  logic [7:0]  Out_tx_data;
  logic        tx_busy, tx_done;
  logic        model_done = 1'b0;
  logic        stray_done = 1'b0;
  logic        model_en   = 1'b1;
  int          tx_cnt     = 0;
  int          cyc        = 0;
  int          last_done_cyc = 0;
  int          timeout_seen  = 0;
  int          n_vec  = 0;
  int          n_fail = 0;

  typedef struct {
    logic [3:0] grant;
    logic [7:0] word;
  } exp_t;

  typedef struct {
    logic [3:0] mask;
    logic [7:0] seed;
    logic [3:0] exp_grant;
    logic [7:0] exp_word;
  } vec_t;

  exp_t       exp_grant_q[$];
  logic [3:0] exp_done_q[$];
  exp_t       mon_e;
  logic [3:0] mon_d;
  vec_t       tbl[8];

  spi_tx_arbiter #(
    .NUM_REQ        (4),
    .DATA_W         (8),
    .GAP_CYCLES     (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .In_clk       (clk),
    .In_rst_n     (rst_n),
    .In_req       (In_req),
    .In_data      (In_data),
    .Out_grant    (Out_grant),
    .Out_done     (Out_done),
    .Out_timeout  (Out_timeout),
    .Out_tx_start (Out_tx_start),
    .Out_tx_data  (Out_tx_data),
    .In_tx_busy   (tx_busy),
    .In_tx_done   (tx_done),
    .Out_busy     (Out_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign tx_done = model_done | stray_done;
  assign tx_busy = (tx_cnt > 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // TX engine model: done pulse 20 cycles after the start pulse.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (!rst_n) begin
      tx_cnt = 0;
    end else begin
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) model_done = 1'b1;
      end
      if (Out_tx_start && model_en) tx_cnt = 20;
    end
  end

  // Scoreboard: grants are matched against pushed expectations, dones against grants.
  always @(negedge clk) begin
    if (Out_grant != 4'b0) begin
      if (exp_grant_q.size() == 0) begin
        check("unexpected_grant", {28'b0, Out_grant}, 32'h0);
      end else begin
        mon_e = exp_grant_q.pop_front();
        check("grant", {28'b0, Out_grant}, {28'b0, mon_e.grant});
        check("grant_word", {24'b0, Out_tx_data}, {24'b0, mon_e.word});
        exp_done_q.push_back(mon_e.grant);
      end
    end
    if (Out_done != 4'b0) begin
      last_done_cyc = cyc;
      if (exp_done_q.size() == 0) begin
        check("unexpected_done", {28'b0, Out_done}, 32'h0);
      end else begin
        mon_d = exp_done_q.pop_front();
        check("done", {28'b0, Out_done}, {28'b0, mon_d});
      end
    end
    if (Out_timeout === 1'b1) timeout_seen++;
  end

  task automatic set_data(input logic [7:0] seed);
    for (int i = 0; i < 4; i++) In_data[i*8 +: 8] = seed + 8'(i);
  endtask

  task automatic push_exp(input logic [3:0] g, input logic [7:0] w);
    exp_t e;
    e.grant = g;
    e.word  = w;
    exp_grant_q.push_back(e);
  endtask

  task automatic wait_idle();
    bit found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (Out_busy === 1'b0) found = 1;
    end
    if (!found) check("wait_idle_timeout", 32'h1, 32'h0);
  endtask

  task automatic wait_grant();
    bit found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (Out_grant != 4'b0) found = 1;
    end
    if (!found) check("wait_grant_timeout", 32'h1, 32'h0);
  endtask

  task automatic wait_done();
    bit found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (Out_done != 4'b0) found = 1;
      else @(negedge clk);
    end
    if (!found) check("wait_done_timeout", 32'h1, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, {28'b0, Out_grant}, 32'h0);
    check({tag, "_done"}, {28'b0, Out_done}, 32'h0);
    check({tag, "_start"}, {31'b0, Out_tx_start}, 32'h0);
    check({tag, "_data"}, {24'b0, Out_tx_data}, 32'h0);
    check({tag, "_busy"}, {31'b0, Out_busy}, 32'h0);
    check({tag, "_timeout"}, {31'b0, Out_timeout}, 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int gsn;
    int dsn;

    // Table: rr pointer is 2 when the table starts (after test 2).
    tbl[0] = '{4'b0100, 8'hA3, 4'b0100, 8'hA5};
    tbl[1] = '{4'b0011, 8'h20, 4'b0001, 8'h20};
    tbl[2] = '{4'b0011, 8'h30, 4'b0010, 8'h31};
    tbl[3] = '{4'b1001, 8'h40, 4'b1000, 8'h43};
    tbl[4] = '{4'b1111, 8'hF0, 4'b0001, 8'hF0};
    tbl[5] = '{4'b1000, 8'h5C, 4'b1000, 8'h5F};
    tbl[6] = '{4'b1010, 8'h00, 4'b0010, 8'h01};
    tbl[7] = '{4'b1000, 8'hFF, 4'b1000, 8'h02};

    // 1: reset with all requests pending
    rst_n  = 1'b0;
    In_req = 4'hF;
    set_data(8'h10);
    repeat (10) @(negedge clk);
    check_all_zero("t1_reset");
    push_exp(4'b0001, 8'h10);
    rst_n = 1'b1;
    wait_grant();
    In_req = 4'b0;
    wait_done();
    wait_idle();

    // 2: single request, cycle-exact latencies
    set_data(8'hA3);
    push_exp(4'b0100, 8'hA5);
    @(negedge clk);
    In_req = 4'b0100;
    @(negedge clk);
    check("t2_grant", {28'b0, Out_grant}, 32'h4);
    check("t2_word", {24'b0, Out_tx_data}, 32'hA5);
    check("t2_busy", {31'b0, Out_busy}, 32'h1);
    check("t2_start_early", {31'b0, Out_tx_start}, 32'h0);
    In_req = 4'b0;
    @(negedge clk);
    check("t2_start", {31'b0, Out_tx_start}, 32'h1);
    check("t2_grant_pulse", {28'b0, Out_grant}, 32'h0);
    k = 0;
    for (int i = 0; i < 40 && Out_done == 4'b0; i++) begin
      @(negedge clk);
      k++;
    end
    check("t2_done_latency", k, 21);
    check("t2_done", {28'b0, Out_done}, 32'h4);
    check("t2_word_held", {24'b0, Out_tx_data}, 32'hA5);
    repeat (3) @(negedge clk);
    check("t2_busy_in_gap", {31'b0, Out_busy}, 32'h1);
    @(negedge clk);
    check("t2_busy_low", {31'b0, Out_busy}, 32'h0);

    // Table-driven single frames
    for (int t = 0; t < 8; t++) begin
      wait_idle();
      set_data(tbl[t].seed);
      push_exp(tbl[t].exp_grant, tbl[t].exp_word);
      @(negedge clk);
      In_req = tbl[t].mask;
      wait_grant();
      In_req = 4'b0;
      wait_done();
    end

    // 3: fairness with all requests held, back-to-back spacing
    wait_idle();
    set_data(8'h10);
    push_exp(4'b0001, 8'h10);
    push_exp(4'b0010, 8'h11);
    push_exp(4'b0100, 8'h12);
    push_exp(4'b1000, 8'h13);
    push_exp(4'b0001, 8'h10);
    @(negedge clk);
    In_req = 4'hF;
    for (int g = 0; g < 5; g++) begin
      wait_grant();
      if (g > 0) check("t3_done_to_grant", cyc - last_done_cyc, 5);
      if (g == 4) In_req = 4'b0;
      @(negedge clk);
      wait_done();
    end

    // 4: request withdrawn during WAIT, stray done during GAP
    wait_idle();
    set_data(8'h60);
    push_exp(4'b0001, 8'h60);
    @(negedge clk);
    In_req = 4'b0001;
    wait_grant();
    In_req = 4'b0;
    repeat (5) @(negedge clk);
    In_req = 4'b0010;
    @(negedge clk);
    In_req = 4'b0;
    wait_done();
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    gsn = 0;
    dsn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (Out_grant != 4'b0) gsn++;
      if (Out_done != 4'b0) dsn++;
    end
    check("t4_no_grant", gsn, 0);
    check("t4_no_done", dsn, 0);
    check("t4_idle", {31'b0, Out_busy}, 32'h0);

    // 5: reset in the middle of a frame
    set_data(8'h70);
    push_exp(4'b0100, 8'h72);
    @(negedge clk);
    In_req = 4'b0100;
    wait_grant();
    In_req = 4'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("t5_reset");
    exp_done_q.delete();
    @(negedge clk);
    push_exp(4'b0001, 8'h70);
    rst_n  = 1'b1;
    In_req = 4'b1001;
    wait_grant();
    In_req = 4'b0;
    wait_done();
    wait_idle();

    // 6: TX engine never answers
    model_en = 1'b0;
    set_data(8'h80);
    push_exp(4'b0010, 8'h81);
`ifdef SPI_ARB_TIMEOUT_EN
    push_exp(4'b1000, 8'h83);
    @(negedge clk);
    In_req = 4'b0010;
    wait_grant();
    In_req = 4'b1000;
    @(negedge clk);
    check("t6_start", {31'b0, Out_tx_start}, 32'h1);
    k = 0;
    for (int i = 0; i < 150 && Out_timeout !== 1'b1; i++) begin
      @(negedge clk);
      k++;
    end
    check("t6_timeout_latency", k, 100);
    check("t6_timeout_done", {28'b0, Out_done}, 32'h2);
    model_en = 1'b1;
    wait_grant();
    check("t6_done_to_grant", cyc - last_done_cyc, 5);
    In_req = 4'b0;
    @(negedge clk);
    wait_done();
    wait_idle();
    check("t6_timeout_count", timeout_seen, 1);
`else
    @(negedge clk);
    In_req = 4'b0010;
    wait_grant();
    In_req = 4'b0;
    repeat (150) @(negedge clk);
    check("t6_still_waiting", {31'b0, Out_busy}, 32'h1);
    check("t6_no_done", {28'b0, Out_done}, 32'h0);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    wait_done();
    model_en = 1'b1;
    wait_idle();
    check("t6_timeout_count", timeout_seen, 0);
`endif

    check("grant_queue_empty", exp_grant_q.size(), 0);
    check("done_queue_empty", exp_done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
